perf_counter_ctrl: RTL and testbench
====================================

# perf_counter_ctrl

Controller for a bank of 64-bit event counters. It sequences start/stop/clear commands and optional fixed-length sampling windows. It serves tear-free counter reads over a 32-bit valid/ready port. It sits between the accelerator's event strobes (stall, MAC-busy, memory-wait) and the host register/debug path, so software can profile a layer run without touching the datapath.

## Interface
Parameters:
- NUM_CNT, 4, number of 64-bit counters (1..16)
- IDX_W, 2, width of rd_idx; must satisfy 2^IDX_W >= NUM_CNT
- WINDOW_W, 32, width of window length

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  00 NOP, 01 START, 10 STOP, 11 CLEAR
- cmd_window  in  WINDOW_W  START only: window length in cycles; 0 = free-running
- event_in  in  NUM_CNT  per-counter increment strobe
- rd_req  in  1  read request, level-sampled in read-idle
- rd_idx  in  IDX_W  counter to read
- rd_valid  out  1  rd_data valid
- rd_data  out  32  read word
- rd_last  out  1  marks upper word
- rd_ready  in  1  consumer accepts word
- running  out  1  high in RUN
- done  out  1  one-cycle pulse on window expiry
- ovf  out  NUM_CNT  sticky wrap flags (see Configuration)

## Operation
- Each counter is stored as two 32-bit halves. The upper half increments only when the lower half equals 32'hFFFF_FFFF. On a 64-bit all-ones value plus an event, the counter wraps to 0.
- Control FSM has two states, IDLE and RUN. Counters increment on event_in[i] only in RUN.
  - IDLE + START: go to RUN; load win_cnt = cmd_window.
  - RUN + START: stay in RUN, reload win_cnt; counters are not cleared.
  - RUN + STOP: go to IDLE, no done pulse. STOP in IDLE is ignored.
  - CLEAR in either state: all counters go to 0 next edge; state is unchanged; win_cnt is untouched.
  - RUN with win_cnt != 0: decrement each cycle. In the cycle win_cnt == 1, events still count, then go to IDLE and pulse done. Exactly cmd_window cycles are counted.
- Read FSM has three states, R_IDLE, R_LO and R_HI.
  - R_IDLE with rd_req: snapshot the full 64 bits of counter[rd_idx] (registered value, before this cycle's increment) into shadow; go to R_LO.
  - R_LO: rd_valid=1, rd_data=shadow[31:0], rd_last=0. Advance to R_HI on rd_ready.
  - R_HI: rd_valid=1, rd_data=shadow[63:32], rd_last=1. Return to R_IDLE on rd_ready.
  - rd_idx >= NUM_CNT snapshots 0.
  - Counters keep counting during a read; the returned value stays coherent.
- cmd_ready is low while the read FSM is in R_LO or R_HI, and high otherwise.

## Timing
- Reset (rst_n=0 at edge): IDLE, R_IDLE, all counters 0, win_cnt 0, shadow 0, ovf 0.
- Outputs during and after reset: running=0, done=0, rd_valid=0, rd_data=0, rd_last=0, cmd_ready=1.
- START accepted at edge N: running=1 after N. Events sampled at edges N+1 onward are counted. Events in the START cycle are not counted.
- CLEAR with event in the same cycle: result is 0; the event is dropped.
- done rises with running falling, for one cycle.
- Read latency: rd_req sampled at edge N gives the low word valid after N. Minimum 2 cycles per read. A back-to-back rd_req is sampled in the cycle R_IDLE is re-entered.
- rd_data and rd_last hold stable while rd_valid && !rd_ready.
- rst_n low mid-read or mid-window: immediate return to the reset state at the next edge. Partial reads are abandoned.

## Configuration
- PERF_CTRL_OVERFLOW_EN defined: ovf[i] sets when counter i wraps from all-ones to 0. It stays set until CLEAR or reset.
- PERF_CTRL_OVERFLOW_EN undefined: no flag logic; ovf is tied to 0.

## Test plan
- START window=10, event_in[0] held high, event_in[1] toggling every cycle (1 at the first counted cycle). Expect counter0=10, counter1=5, done pulse after the 10th counted cycle, running=0.
- Counter 2 preloaded via 0xFFFF_FFFF events (force), one more event. Expect read words 0x0000_0000 then 0x0000_0001 with rd_last on the second.
- Free-running START with event_in[3]=1. Issue rd_req idx=3 and hold rd_ready=0 for 5 cycles. Expect rd_data frozen and the snapshot value unchanged while the live counter advances by 5+.
- CLEAR while running with all events high. Expect all counters to read 0 and running to remain 1. Then STOP gives no done pulse.
- With PERF_CTRL_OVERFLOW_EN: force counter1 to all-ones, then one event. Expect ovf=4'b0010 and value 0. CLEAR returns ovf=0.
- Assert rst_n=0 during R_HI. Expect rd_valid=0 and cmd_ready=1 next cycle, and all counters 0.

Source files
------------

// File: rtl/perf_counter_ctrl.sv
// ---------------------------------------------------------------------------
// perf_counter_ctrl
//
// Controller for a bank of NUM_CNT 64-bit event counters. The counters run
// only while the control FSM is in RUN. A START command can carry a
// sampling window of cmd_window_i cycles, where 0 means free-running. The
// counters are read over a 32-bit valid/ready port: low word first, then
// the high word tagged with rd_last_o. Each read returns a snapshot taken
// when the request is accepted, so the two words always belong together.
//
// Ports
//   clk_i, rst_n_i      clock; synchronous active-low reset
//   cmd_valid_i/ready_o command handshake; cmd_op_i 00 NOP 01 START
//                       10 STOP 11 CLEAR; cmd_window_i window for START
//   event_in_i          per-counter increment strobes
//   rd_req_i, rd_idx_i  read request (level) and counter index
//   rd_valid_o, rd_data_o, rd_last_o, rd_ready_i  read word stream
//   running_o           high while counting
//   done_o              one-cycle pulse when a window expires
//   ovf_o               sticky wrap flags
//
// Build option
//   PERF_CTRL_OVERFLOW_EN  when defined, ovf_o[i] latches a 64-bit wrap of
//                          counter i and clears on CLEAR or reset. When
//                          undefined, ovf_o is tied to 0.
// ---------------------------------------------------------------------------

// One 64-bit counter kept as two 32-bit halves. The high half only moves on
// a carry out of the low half.
module perf_cnt_lane (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [63:0] val_o,
  output logic        wrap_o
);
  logic [31:0] lo_q, lo_d, hi_q, hi_d;
  logic        lo_full, hi_full;

  assign lo_full = (lo_q == 32'hFFFF_FFFF);
  assign hi_full = (hi_q == 32'hFFFF_FFFF);

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    // CLEAR wins over a coincident event, so that event is dropped.
    if (clr_i) begin
      lo_d = '0;
      hi_d = '0;
    end else if (inc_i) begin
      lo_d = lo_q + 32'd1;
      if (lo_full) hi_d = hi_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign val_o  = {hi_q, lo_q};
  assign wrap_o = inc_i && !clr_i && lo_full && hi_full;
endmodule

module perf_counter_ctrl #(
  parameter int NUM_CNT  = 4,
  parameter int IDX_W    = 2,
  parameter int WINDOW_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [WINDOW_W-1:0] cmd_window_i,
  input  logic [NUM_CNT-1:0]  event_in_i,
  input  logic                rd_req_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic                rd_valid_o,
  output logic [31:0]         rd_data_o,
  output logic                rd_last_o,
  input  logic                rd_ready_i,
  output logic                running_o,
  output logic                done_o,
  output logic [NUM_CNT-1:0]  ovf_o
);
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic       {C_IDLE, C_RUN}       cst_e;
  typedef enum logic [1:0] {R_IDLE, R_LO, R_HI}  rst_e;

  cst_e                 cst_q, cst_d;
  rst_e                 rst_q, rst_d;
  logic [WINDOW_W-1:0]  win_q, win_d;
  logic                 done_q, done_d;
  logic [63:0]          shadow_q, shadow_d;

  logic                 cmd_fire, is_start, is_stop, is_clear;
  logic                 run;
  logic [NUM_CNT-1:0][63:0] cnt_val;
  logic [NUM_CNT-1:0]   wrap;
  logic [63:0]          sel_val;

  assign cmd_fire = cmd_valid_i && cmd_ready_o;
  assign is_start = cmd_fire && (cmd_op_i == OP_START);
  assign is_stop  = cmd_fire && (cmd_op_i == OP_STOP);
  assign is_clear = cmd_fire && (cmd_op_i == OP_CLEAR);
  assign run      = (cst_q == C_RUN);

  // -------------------------------------------------------------------------
  // Counter bank
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CNT; g++) begin : g_lane
    perf_cnt_lane u_lane (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .clr_i  (is_clear),
      .inc_i  (event_in_i[g] && run),
      .val_o  (cnt_val[g]),
      .wrap_o (wrap[g])
    );
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cst_q  <= C_IDLE;
      win_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cst_q  <= cst_d;
      win_q  <= win_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    cst_d  = cst_q;
    win_d  = win_q;
    done_d = 1'b0;
    case (cst_q)
      C_IDLE: begin
        if (is_start) begin
          cst_d = C_RUN;
          win_d = cmd_window_i;
        end
      end
      C_RUN: begin
        // Explicit commands take priority over window expiry.
        if (is_stop) begin
          cst_d = C_IDLE;
        end else if (is_start) begin
          win_d = cmd_window_i;
        end else if (win_q != '0) begin
          win_d = win_q - WINDOW_W'(1);
          // The win_q == 1 cycle is the last counted cycle. done is
          // registered so that it rises together with running falling.
          if (win_q == WINDOW_W'(1)) begin
            cst_d  = C_IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: cst_d = C_IDLE;
    endcase
  end

  always_comb begin
    running_o = run;
    done_o    = done_q;
  end

  // -------------------------------------------------------------------------
  // Read FSM
  // -------------------------------------------------------------------------
  // An out-of-range index falls through the loop and leaves sel_val at 0.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_CNT; i++)
      if (int'(rd_idx_i) == i) sel_val = cnt_val[i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rst_q    <= R_IDLE;
      shadow_q <= '0;
    end else begin
      rst_q    <= rst_d;
      shadow_q <= shadow_d;
    end
  end

  // The snapshot takes the registered counter value, which is the value
  // before this cycle's increment. Both halves then come from one instant.
  always_comb begin
    rst_d    = rst_q;
    shadow_d = shadow_q;
    case (rst_q)
      R_IDLE: begin
        if (rd_req_i) begin
          rst_d    = R_LO;
          shadow_d = sel_val;
        end
      end
      R_LO:    if (rd_ready_i) rst_d = R_HI;
      R_HI:    if (rd_ready_i) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_valid_o  = 1'b0;
    rd_data_o   = '0;
    rd_last_o   = 1'b0;
    cmd_ready_o = 1'b1;
    case (rst_q)
      R_LO: begin
        rd_valid_o  = 1'b1;
        rd_data_o   = shadow_q[31:0];
        cmd_ready_o = 1'b0;
      end
      R_HI: begin
        rd_valid_o  = 1'b1;
        rd_data_o   = shadow_q[63:32];
        rd_last_o   = 1'b1;
        cmd_ready_o = 1'b0;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Overflow flags
  // -------------------------------------------------------------------------
`ifdef PERF_CTRL_OVERFLOW_EN
  logic [NUM_CNT-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | wrap;
    if (is_clear) ovf_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ovf_q <= '0;
    else          ovf_q <= ovf_d;
  end

  assign ovf_o = ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
  assign ovf_o       = '0;
`endif

endmodule

// File: tb/tb_perf_counter_ctrl.sv
module tb_perf_counter_ctrl;
  localparam int NUM_CNT  = 4;
  localparam int IDX_W    = 2;
  localparam int WINDOW_W = 32;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = OP_NOP;
  logic [WINDOW_W-1:0] cmd_window = '0;
  logic [NUM_CNT-1:0]  ev = '0;
  logic                rd_req = 1'b0;
  logic [IDX_W-1:0]    rd_idx = '0;
  logic                rd_valid;
  logic [31:0]         rd_data;
  logic                rd_last;
  logic                rd_ready = 1'b0;
  logic                running;
  logic                done;
  logic [NUM_CNT-1:0]  ovf;

  int nvec = 0;
  int nerr = 0;

  perf_counter_ctrl #(.NUM_CNT(NUM_CNT), .IDX_W(IDX_W), .WINDOW_W(WINDOW_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_window_i(cmd_window), .event_in_i(ev),
    .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .rd_ready_i(rd_ready),
    .running_o(running), .done_o(done), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // flags = {running, done, rd_valid, rd_last, cmd_ready}
  typedef struct packed {
    logic        cv;
    logic [1:0]  op;
    logic [31:0] win;
    logic [3:0]  ev;
    logic        rq;
    logic [1:0]  idx;
    logic        rr;
    logic [4:0]  flags;
    logic [31:0] data;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic cv, logic [1:0] op, logic [31:0] win, logic [3:0] e,
                              logic rq, logic [1:0] idx, logic rr,
                              logic [4:0] flags, logic [31:0] data);
    vec_t v;
    v.cv = cv; v.op = op; v.win = win; v.ev = e; v.rq = rq; v.idx = idx; v.rr = rr;
    v.flags = flags; v.data = data;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] w);
    cmd_valid = 1'b1; cmd_op = op; cmd_window = w;
    tick();
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_window = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ev = '0; cmd_valid = 1'b0; rd_req = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic do_read(input logic [1:0] idx, input logic [63:0] exp, input string name);
    logic [31:0] lo, hi;
    lo = exp[31:0];
    hi = exp[63:32];
    rd_idx = idx; rd_req = 1'b1; rd_ready = 1'b1;
    tick();
    rd_req = 1'b0;
    chk({name, " lo"}, {30'd0, rd_valid, rd_last, rd_data}, {30'd0, 1'b1, 1'b0, lo});
    tick();
    chk({name, " hi"}, {30'd0, rd_valid, rd_last, rd_data}, {30'd0, 1'b1, 1'b1, hi});
    tick();
    chk({name, " end"}, {62'd0, rd_valid, cmd_ready}, {62'd0, 2'b01});
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_ovf;

    // ---------------- reset state ----------------
    do_reset();
    chk("reset outputs", {26'd0, running, done, rd_valid, rd_last, cmd_ready, ovf, rd_data},
        {26'd0, 5'b00001, 4'b0000, 32'd0});

    // ---------------- vector table: window of 10 + reads ----------------
    vq.push_back(mk(1, OP_START, 10, 4'b0000, 0, 0, 0, 5'b10001, 0));
    for (int k = 1; k <= 10; k++)
      vq.push_back(mk(0, OP_NOP, 0, {2'b00, 1'(k % 2), 1'b1}, 0, 0, 0,
                      {1'(k < 10), 1'(k == 10), 3'b001}, 0));
    vq.push_back(mk(0, OP_NOP, 0, 4'b0011, 0, 0, 0, 5'b00001, 0));  // idle: not counted
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 1, 0, 0, 5'b00100, 10)); // read c0 low
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 0, 0, 0, 5'b00100, 10)); // hold low
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 0, 0, 1, 5'b00110, 0));  // high
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 0, 0, 1, 5'b00001, 0));  // idle
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 1, 1, 1, 5'b00100, 5));  // read c1 low
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 1, 1, 1, 5'b00110, 0));  // high, req ignored
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 1, 0, 1, 5'b00001, 0));  // back in idle
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 1, 0, 1, 5'b00100, 10)); // back-to-back c0
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 0, 0, 1, 5'b00110, 0));
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 0, 0, 0, 5'b00110, 0));  // hold high
    vq.push_back(mk(0, OP_NOP, 0, 4'b0000, 0, 0, 1, 5'b00001, 0));

    foreach (vq[i]) begin
      cmd_valid = vq[i].cv; cmd_op = vq[i].op; cmd_window = vq[i].win; ev = vq[i].ev;
      rd_req = vq[i].rq; rd_idx = vq[i].idx; rd_ready = vq[i].rr;
      tick();
      chk($sformatf("vec%0d", i),
          {27'd0, running, done, rd_valid, rd_last, cmd_ready, rd_data},
          {27'd0, vq[i].flags, vq[i].data});
    end
    cmd_valid = 1'b0; ev = '0; rd_req = 1'b0; rd_ready = 1'b0;

    // ---------------- low-half carry into high half ----------------
    do_reset();
    force dut.g_lane[2].u_lane.lo_q = 32'hFFFF_FFFF;
    tick();
    release dut.g_lane[2].u_lane.lo_q;
    cmd(OP_START, 0);
    ev = 4'b0100;
    tick();
    ev = '0;
    cmd(OP_STOP, 0);
    do_read(2, 64'h0000_0001_0000_0000, "carry c2");

    // ---------------- coherent read while counting ----------------
    do_reset();
    cmd(OP_START, 0);
    ev = 4'b1000;
    tick(); tick(); tick();
    rd_idx = 3; rd_req = 1'b1; rd_ready = 1'b0;
    tick();
    rd_req = 1'b0;
    chk("snap lo", {31'd0, rd_valid, rd_data}, {31'd0, 1'b1, 32'd3});
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold%0d", k), {30'd0, rd_valid, rd_last, rd_data}, {30'd0, 2'b10, 32'd3});
    end
    rd_ready = 1'b1;
    tick();
    chk("snap hi", {30'd0, rd_valid, rd_last, rd_data}, {30'd0, 2'b11, 32'd0});
    tick();
    rd_ready = 1'b0;
    ev = '0;
    cmd(OP_STOP, 0);
    do_read(3, 64'd11, "live c3");

    // ---------------- CLEAR while running ----------------
    cmd(OP_START, 0);
    ev = 4'b1111;
    tick(); tick(); tick();
    cmd(OP_CLEAR, 0);
    ev = '0;
    chk("clear running", {63'd0, running}, 64'd1);
    for (int k = 0; k < 4; k++) do_read(2'(k), 64'd0, $sformatf("clr c%0d", k));
    cmd(OP_STOP, 0);
    chk("stop no done", {62'd0, running, done}, 64'd0);

    // ---------------- 64-bit wrap ----------------
    do_reset();
    force dut.g_lane[1].u_lane.lo_q = 32'hFFFF_FFFF;
    force dut.g_lane[1].u_lane.hi_q = 32'hFFFF_FFFF;
    tick();
    release dut.g_lane[1].u_lane.lo_q;
    release dut.g_lane[1].u_lane.hi_q;
    cmd(OP_START, 0);
    ev = 4'b0010;
    tick();
    ev = '0;
    cmd(OP_STOP, 0);
`ifdef PERF_CTRL_OVERFLOW_EN
    exp_ovf = 4'b0010;
`else
    exp_ovf = 4'b0000;
`endif
    chk("ovf set", {60'd0, ovf}, {60'd0, exp_ovf});
    do_read(1, 64'd0, "wrap c1");
    cmd(OP_CLEAR, 0);
    chk("ovf clear", {60'd0, ovf}, 64'd0);

    // ---------------- reset during high word ----------------
    cmd(OP_START, 0);
    ev = 4'b1111;
    tick(); tick();
    rd_idx = 0; rd_req = 1'b1; rd_ready = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    chk("in hi", {62'd0, rd_valid, rd_last}, {62'd0, 2'b11});
    rst_n = 1'b0; rd_ready = 1'b0;
    tick();
    chk("rst mid-read", {27'd0, rd_valid, rd_last, cmd_ready, running, done, rd_data},
        {27'd0, 5'b00100, 32'd0});
    ev = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) do_read(2'(k), 64'd0, $sformatf("rst c%0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
